dma_chan_addr_count_regs: RTL

Per-channel base/current address and word-count register file for the 8237A-compatible DMA model, sitting directly downstream of the software-command decoder. It consumes the decoded register read/write strobes plus the 8-bit data bus, and maintains the byte-pointer flip-flop that steers low/high byte accesses. During service it updates the current registers on each transfer strobe from the timing-control block and flags terminal count (TC).

---
 rtl/dma_chan_addr_count_regs.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/dma_chan_addr_count_regs.sv
// dma_chan_addr_count_regs
//   Per-channel base/current address and word-count registers for the
//   8237A-compatible DMA model, with the shared byte pointer (BP) that
//   steers low/high byte accesses from the 8-bit CPU bus. Current registers
//   advance on each transfer strobe from timing control; terminal count is
//   flagged with a one-cycle TC pulse.
//
// Ports
//   CLK, RESET_N              clock, asynchronous active-low reset
//   CS_N                      chip select; command strobes ignored while high
//   WR_BASE_ADDR_CMD[n]       write base+current address of channel n
//   RD_CURR_ADDR_CMD[n]       read current address of channel n
//   WR_BASE_WC_CMD[n]         write base+current word count of channel n
//   RD_CURR_WC_CMD[n]         read current word count of channel n
//   CLEAR/SET_BYTE_POINTER_CMD, MASTER_CLEAR_CMD   decoder strobes
//   DB_IN / DB_OUT / DB_OE    CPU data bus write byte, read byte, read enable
//   XFER_STB, XFER_CH         one-cycle transfer-done pulse and its channel
//   ADDR_DEC, AUTOINIT        mode bits of the serviced channel
//   CURR_ADDR                 current address of XFER_CH (combinational)
//   TC, TC_CH                 terminal-count pulse and its channel
module dma_chan_addr_count_regs #(
  parameter int NUM_CH = 4,
  parameter int AW     = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CS_N,
  input  logic [NUM_CH-1:0] WR_BASE_ADDR_CMD,
  input  logic [NUM_CH-1:0] RD_CURR_ADDR_CMD,
  input  logic [NUM_CH-1:0] WR_BASE_WC_CMD,
  input  logic [NUM_CH-1:0] RD_CURR_WC_CMD,
  input  logic              CLEAR_BYTE_POINTER_CMD,
  input  logic              SET_BYTE_POINTER_CMD,
  input  logic              MASTER_CLEAR_CMD,
  input  logic [7:0]        DB_IN,
  output logic [7:0]        DB_OUT,
  output logic              DB_OE,
  input  logic              XFER_STB,
  input  logic [1:0]        XFER_CH,
  input  logic              ADDR_DEC,
  input  logic              AUTOINIT,
  output logic [AW-1:0]     CURR_ADDR,
  output logic              TC,
  output logic [1:0]        TC_CH
);

  localparam int N  = NUM_CH;
  localparam int SW = 4 * N + 3;

  // Illegal multi-hot strobe vectors resolve to the lowest channel.
  function automatic logic [N-1:0] lowest_hot(input logic [N-1:0] v);
    return v & (~v + N'(1));
  endfunction

  function automatic logic [AW-1:0] put_byte(input logic [AW-1:0] r,
                                             input logic hi,
                                             input logic [7:0] b);
    return hi ? {b, r[7:0]} : {r[AW-1:8], b};
  endfunction

  function automatic logic [7:0] get_byte(input logic [AW-1:0] r, input logic hi);
    return hi ? r[AW-1:8] : r[7:0];
  endfunction

  // Strobe vector layout: [N-1:0] wr addr, [2N-1:N] rd addr, [3N-1:2N] wr wc,
  // [4N-1:3N] rd wc, then clear BP, set BP, master clear.
  logic [SW-1:0] cmd_raw;
  logic [SW-1:0] stb1_q, stb2_q, ign_q, live;
  logic          armed_q;
  logic [7:0]    db_q;

  assign cmd_raw = CS_N ? '0 :
                   {MASTER_CLEAR_CMD, SET_BYTE_POINTER_CMD, CLEAR_BYTE_POINTER_CMD,
                    lowest_hot(RD_CURR_WC_CMD), lowest_hot(WR_BASE_WC_CMD),
                    lowest_hot(RD_CURR_ADDR_CMD), lowest_hot(WR_BASE_ADDR_CMD)};

  // Stage p0 -> p1: register strobes, then a second stage for edge history.
  // ign_q masks any strobe already high when reset releases, so neither its
  // apparent rise nor its later fall is acted on.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stb1_q  <= '0;
      stb2_q  <= '0;
      ign_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      stb1_q  <= cmd_raw;
      stb2_q  <= stb1_q;
      armed_q <= 1'b1;
      if (!armed_q) ign_q <= cmd_raw;
      else          ign_q <= ign_q & (stb1_q | stb2_q);
    end
  end

  always_ff @(posedge CLK) begin
    db_q <= DB_IN;
  end

  logic [N-1:0] wa_rise, wc_rise;
  logic         clr_rise, set_rise, mc_rise, bp_toggle;

  assign live      = stb1_q & ~ign_q;
  assign wa_rise   = live[N-1:0]     & ~stb2_q[N-1:0];
  assign wc_rise   = live[3*N-1:2*N] & ~stb2_q[3*N-1:2*N];
  assign clr_rise  = live[4*N]       & ~stb2_q[4*N];
  assign set_rise  = live[4*N+1]     & ~stb2_q[4*N+1];
  assign mc_rise   = live[4*N+2]     & ~stb2_q[4*N+2];
  assign bp_toggle = |(~stb1_q[4*N-1:0] & stb2_q[4*N-1:0] & ~ign_q[4*N-1:0]);

  logic [AW-1:0] base_addr_q [N];
  logic [AW-1:0] curr_addr_q [N];
  logic [AW-1:0] base_wc_q   [N];
  logic [AW-1:0] curr_wc_q   [N];
  logic [AW-1:0] base_addr_d [N];
  logic [AW-1:0] curr_addr_d [N];
  logic [AW-1:0] base_wc_d   [N];
  logic [AW-1:0] curr_wc_d   [N];
  logic          bp_q, bp_d;
  logic          tc_q, tc_d;
  logic [1:0]    tc_ch_q, tc_ch_d;

  // A programming write to the serviced channel, or a master clear, drops the
  // transfer update entirely (including its TC).
  logic xfer_go, xfer_last;
  assign xfer_go   = XFER_STB & ~mc_rise & ~wa_rise[XFER_CH] & ~wc_rise[XFER_CH];
  assign xfer_last = (curr_wc_q[XFER_CH] == '0);

  always_comb begin
    base_addr_d = base_addr_q;
    curr_addr_d = curr_addr_q;
    base_wc_d   = base_wc_q;
    curr_wc_d   = curr_wc_q;
    bp_d        = bp_q;
    tc_d        = 1'b0;
    tc_ch_d     = tc_ch_q;

    if (xfer_go) begin
      if (xfer_last && AUTOINIT) begin
        curr_addr_d[XFER_CH] = base_addr_q[XFER_CH];
        curr_wc_d[XFER_CH]   = base_wc_q[XFER_CH];
      end else begin
        curr_addr_d[XFER_CH] = ADDR_DEC ? curr_addr_q[XFER_CH] - AW'(1)
                                        : curr_addr_q[XFER_CH] + AW'(1);
        curr_wc_d[XFER_CH]   = curr_wc_q[XFER_CH] - AW'(1);
      end
      tc_d    = xfer_last;
      tc_ch_d = XFER_CH;
    end

    for (int i = 0; i < N; i++) begin
      if (wa_rise[i]) begin
        base_addr_d[i] = put_byte(base_addr_q[i], bp_q, db_q);
        curr_addr_d[i] = put_byte(curr_addr_q[i], bp_q, db_q);
      end
      if (wc_rise[i]) begin
        base_wc_d[i] = put_byte(base_wc_q[i], bp_q, db_q);
        curr_wc_d[i] = put_byte(curr_wc_q[i], bp_q, db_q);
      end
    end

    if (bp_toggle) bp_d = ~bp_q;
    if (clr_rise)  bp_d = 1'b0;
    if (set_rise)  bp_d = 1'b1;

    if (mc_rise) begin
      for (int i = 0; i < N; i++) begin
        base_addr_d[i] = '0;
        curr_addr_d[i] = '0;
        base_wc_d[i]   = '0;
        curr_wc_d[i]   = '0;
      end
      bp_d = 1'b0;
      tc_d = 1'b0;
    end
  end

  // Stage p1 -> p2: register file, byte pointer and TC state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < N; i++) begin
        base_addr_q[i] <= '0;
        curr_addr_q[i] <= '0;
        base_wc_q[i]   <= '0;
        curr_wc_q[i]   <= '0;
      end
      bp_q    <= 1'b0;
      tc_q    <= 1'b0;
      tc_ch_q <= '0;
    end else begin
      base_addr_q <= base_addr_d;
      curr_addr_q <= curr_addr_d;
      base_wc_q   <= base_wc_d;
      curr_wc_q   <= curr_wc_d;
      bp_q        <= bp_d;
      tc_q        <= tc_d;
      tc_ch_q     <= tc_ch_d;
    end
  end

  // Read-back mux; address reads take precedence, lowest channel wins.
  always_comb begin
    DB_OUT = 8'h00;
    DB_OE  = (|live[2*N-1:N]) | (|live[4*N-1:3*N]);
    for (int i = N - 1; i >= 0; i--) begin
      if (live[3*N+i]) DB_OUT = get_byte(curr_wc_q[i], bp_q);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (live[N+i]) DB_OUT = get_byte(curr_addr_q[i], bp_q);
    end
  end

  assign CURR_ADDR = curr_addr_q[XFER_CH];
  assign TC        = tc_q;
  assign TC_CH     = tc_ch_q;

endmodule
